// File: rtl/mem_pkg.sv
// Shared memory-interface types: block layout, responder states, index-width helpers.
package mem_pkg;

    localparam int MEM_DATA_W     = 32;
    localparam int MEM_BLOCK_SIZE = 16;

    typedef logic [MEM_BLOCK_SIZE-1:0][MEM_DATA_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic int offset_w(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic int idx_w(input int mem_blocks);
        return $clog2(mem_blocks);
    endfunction

endpackage

// File: rtl/mem_block_array.sv
// Block storage: synchronous write port, combinational read port, no reset.
module mem_block_array #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IW-1:0]    widx,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IW-1:0]    ridx,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/main_mem_responder.sv
// Block-granular main-memory responder for the L2 refill interface.
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 16,
    parameter int MEM_BLOCKS = 256,
    parameter int LATENCY    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block,
    output logic                             mem_ready,
    output logic                             mem_busy
);

    localparam int OW = offset_w(BLOCK_SIZE);
    localparam int IW = idx_w(MEM_BLOCKS);
    localparam int BW = BLOCK_SIZE * DATA_WIDTH;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t        state;
    logic [7:0]    cnt;
    logic [IW-1:0] blk_idx;
    logic [IW-1:0] cap_idx;
    logic [IW-1:0] ridx;
    logic [BW-1:0] rdata;
    logic          req;
    logic          we;
    logic          unused_addr;

    assign blk_idx     = mem_addr[OW+IW-1:OW];
    assign unused_addr = ^{mem_addr[ADDR_WIDTH-1:OW+IW], mem_addr[OW-1:0]};
    assign req         = mem_read | mem_write;
    assign we          = (state == IDLE) & mem_write;
    assign ridx        = (state == IDLE) ? blk_idx : cap_idx;
    assign mem_busy    = (state != IDLE);

    mem_block_array #(
        .WIDTH(BW),
        .DEPTH(MEM_BLOCKS),
        .IW   (IW)
    ) u_array (
        .clk  (clk),
        .we   (we),
        .widx (blk_idx),
        .wdata(mem_data_out),
        .ridx (ridx),
        .rdata(rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            cap_idx        <= '0;
            mem_ready      <= 1'b0;
            mem_data_block <= '0;
        end else begin
            mem_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        cap_idx <= blk_idx;
                        cnt     <= CNT_INIT;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                        end else begin
                            // Single-cycle latency: the write lands on this
                            // same edge, so forward it instead of the array.
                            state          <= RESP;
                            mem_ready      <= 1'b1;
                            mem_data_block <= mem_write ? mem_data_out : rdata;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state          <= RESP;
                        mem_ready      <= 1'b1;
                        mem_data_block <= rdata;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized self-checking bench for main_mem_responder (LATENCY 4 and LATENCY 1 builds).
module tb_main_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] addr4 = '0;
    logic        rd4 = 1'b0;
    logic        wr4 = 1'b0;
    block_t      din4 = '0;
    logic [511:0] blk4;
    logic        rdy4;
    logic        busy4;

    logic [31:0] addr1 = '0;
    logic        rd1 = 1'b0;
    logic        wr1 = 1'b0;
    block_t      din1 = '0;
    logic [511:0] blk1;
    logic        rdy1;
    logic        busy1;

    int tests = 0;
    int fails = 0;

    block_t ref4 [256];
    block_t ref1 [256];

    always #5 clk = ~clk;

    main_mem_responder #(.LATENCY(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (addr4),
        .mem_read      (rd4),
        .mem_write     (wr4),
        .mem_data_out  (din4),
        .mem_data_block(blk4),
        .mem_ready     (rdy4),
        .mem_busy      (busy4)
    );

    main_mem_responder #(.LATENCY(1)) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (addr1),
        .mem_read      (rd1),
        .mem_write     (wr1),
        .mem_data_out  (din1),
        .mem_data_block(blk1),
        .mem_ready     (rdy1),
        .mem_busy      (busy1)
    );

    function automatic block_t ramp(input logic [31:0] base);
        block_t b;
        for (int i = 0; i < 16; i++) b[i] = base + 32'(i);
        return b;
    endfunction

    function automatic block_t rnd_block();
        block_t b;
        for (int i = 0; i < 16; i++) b[i] = $urandom;
        return b;
    endfunction

    // Drives one request on the selected DUT and observes cycles-to-ready
    // (counted in posedges from request presentation), busy cycles and pulses.
    task automatic xact(input bit sel, input logic [31:0] a, input logic rd,
                        input logic wr, input block_t d, input bit drop,
                        output int lat, output int bcyc, output int pulses,
                        output block_t got);
        logic r;
        logic b;
        @(negedge clk);
        if (sel) begin addr1 = a; rd1 = rd; wr1 = wr; din1 = d; end
        else begin addr4 = a; rd4 = rd; wr4 = wr; din4 = d; end
        lat = -1; bcyc = 0; pulses = 0; got = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            r = sel ? rdy1 : rdy4;
            b = sel ? busy1 : busy4;
            if (drop && lat < 0) begin
                rd4 = 1'b0; wr4 = 1'b0;
                if (i > 1) addr4 = $urandom;
            end
            if (b) bcyc++;
            if (r) begin
                pulses++;
                if (lat < 0) begin
                    lat = i;
                    got = sel ? blk1 : blk4;
                end
                if (sel) begin rd1 = 1'b0; wr1 = 1'b0; end
                else begin rd4 = 1'b0; wr4 = 1'b0; end
            end
            if (lat > 0 && i >= lat + 6) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (rdy4 !== 1'b0 || busy4 !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl4: ready=%b busy=%b want 0 0", rdy4, busy4);
        end
        tests++;
        if (blk4 !== '0) begin
            fails++;
            $display("FAIL reset_data4: got %h want 0", blk4);
        end
        tests++;
        if (rdy1 !== 1'b0 || busy1 !== 1'b0 || blk1 !== '0) begin
            fails++;
            $display("FAIL reset_lat1: ready=%b busy=%b data_nz=%b want 0 0 0",
                     rdy1, busy1, blk1 != '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        int lat, bc, np;
        block_t got, pat;
        pat = ramp(32'hA5A5_0000);
        ref4[8'h40] = pat;
        xact(0, 32'h400, 0, 1, pat, 0, lat, bc, np, got);
        tests++;
        if (lat != 4 || np != 1 || bc != 4) begin
            fails++;
            $display("FAIL wr_timing: lat=%0d pulses=%0d busy=%0d want 4 1 4", lat, np, bc);
        end
        tests++;
        if (got !== pat) begin
            fails++;
            $display("FAIL wr_data: got %h want %h", got, pat);
        end
        xact(0, 32'h400, 1, 0, rnd_block(), 0, lat, bc, np, got);
        tests++;
        if (lat != 4 || np != 1) begin
            fails++;
            $display("FAIL rd_timing: lat=%0d pulses=%0d want 4 1", lat, np);
        end
        tests++;
        if (got !== ref4[8'h40]) begin
            fails++;
            $display("FAIL rd_data: got %h want %h", got, ref4[8'h40]);
        end
    endtask

    task automatic test_latency1();
        int lat, bc, np;
        block_t got, pat;
        pat = rnd_block();
        ref1[8'h23] = pat;
        xact(1, 32'h230, 0, 1, pat, 0, lat, bc, np, got);
        tests++;
        if (lat != 1 || bc != 1 || np != 1 || got !== pat) begin
            fails++;
            $display("FAIL lat1_write: lat=%0d busy=%0d pulses=%0d data_ok=%b want 1 1 1 1",
                     lat, bc, np, got === pat);
        end
        xact(1, 32'h230, 1, 0, rnd_block(), 0, lat, bc, np, got);
        tests++;
        if (lat != 1 || bc != 1 || np != 1) begin
            fails++;
            $display("FAIL lat1_read_timing: lat=%0d busy=%0d pulses=%0d want 1 1 1", lat, bc, np);
        end
        tests++;
        if (got !== ref1[8'h23]) begin
            fails++;
            $display("FAIL lat1_read_data: got %h want %h", got, ref1[8'h23]);
        end
    endtask

    task automatic test_rw_same();
        int lat, bc, np;
        block_t got, pat;
        for (int i = 0; i < 16; i++) pat[i] = 32'h1234_5678;
        ref4[8'h01] = pat;
        xact(0, 32'h10, 1, 1, pat, 0, lat, bc, np, got);
        tests++;
        if (lat != 4 || np != 1) begin
            fails++;
            $display("FAIL rw_timing: lat=%0d pulses=%0d want 4 1", lat, np);
        end
        tests++;
        if (got !== pat) begin
            fails++;
            $display("FAIL rw_data: got %h want %h", got, pat);
        end
    endtask

    task automatic test_drop();
        int lat, bc, np;
        block_t got;
        xact(0, 32'h400, 1, 0, rnd_block(), 1, lat, bc, np, got);
        tests++;
        if (lat != 4 || np != 1 || bc != 4) begin
            fails++;
            $display("FAIL drop_timing: lat=%0d pulses=%0d busy=%0d want 4 1 4", lat, np, bc);
        end
        tests++;
        if (got !== ref4[8'h40]) begin
            fails++;
            $display("FAIL drop_data: got %h want %h", got, ref4[8'h40]);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, np, late;
        block_t got;
        @(negedge clk);
        addr4 = 32'h400; rd4 = 1'b1;
        @(posedge clk); #1;
        rd4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (rdy4 !== 1'b0 || busy4 !== 1'b0 || blk4 !== '0) begin
            fails++;
            $display("FAIL reset_mid: ready=%b busy=%b data_nz=%b want 0 0 0",
                     rdy4, busy4, blk4 != '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        late = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rdy4 || busy4) late++;
        end
        tests++;
        if (late != 0) begin
            fails++;
            $display("FAIL reset_no_pulse: active cycles=%0d want 0", late);
        end
        xact(0, 32'h400, 1, 0, rnd_block(), 0, lat, bc, np, got);
        tests++;
        if (lat != 4 || got !== ref4[8'h40]) begin
            fails++;
            $display("FAIL reset_retain: lat=%0d got %h want 4 %h", lat, got, ref4[8'h40]);
        end
    endtask

    task automatic test_alias();
        int lat, bc, np;
        block_t got, pat;
        pat = rnd_block();
        ref4[8'h01] = pat;
        xact(0, 32'h0000_0010, 0, 1, pat, 0, lat, bc, np, got);
        xact(0, 32'h0001_0010, 1, 0, rnd_block(), 0, lat, bc, np, got);
        tests++;
        if (lat != 4 || got !== pat) begin
            fails++;
            $display("FAIL alias: lat=%0d got %h want 4 %h", lat, got, pat);
        end
    endtask

    task automatic test_random();
        int lat, bc, np, k;
        logic [31:0] r, a;
        logic [7:0] idx;
        block_t got, d, exp;
        for (int i = 0; i < 8; i++) begin
            d = rnd_block();
            ref4[i] = d;
            xact(0, 32'(i) << 4, 0, 1, d, 0, lat, bc, np, got);
        end
        for (int n = 0; n < 24; n++) begin
            r = $urandom;
            idx = 8'($urandom_range(0, 7));
            a = {r[31:12], idx, r[3:0]};
            k = $urandom_range(0, 2);
            d = rnd_block();
            if (k != 0) ref4[idx] = d;
            exp = ref4[idx];
            xact(0, a, k != 1, k != 0, d, n[0], lat, bc, np, got);
            tests++;
            if (lat != 4 || np != 1 || bc != 4 || got !== exp) begin
                fails++;
                $display("FAIL rand_%0d: addr=%h op=%0d lat=%0d pulses=%0d busy=%0d data_ok=%b",
                         n, a, k, lat, np, bc, got === exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency1();
        test_rw_same();
        test_drop();
        test_reset_mid();
        test_alias();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
